// File: rtl/reg_file_swap.sv
`default_nettype none
// reg_file_swap: 2**AW x W register file, two combinational read ports, one write
// port, optional write bypass and a two-cycle hardware swap. Rev 1.0
module reg_file_swap #(
  parameter int W      = 8,
  parameter int AW     = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  dat_in,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [W-1:0]  datA_out,
  output logic [W-1:0]  datB_out,
  input  logic          swap_req,
  input  logic [AW-1:0] swap_a,
  input  logic [AW-1:0] swap_b,
  output logic          busy,
  output logic          swap_done,
  output logic          wr_drop
);

  localparam int C_DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWAP1 = 2'd1,
    ST_SWAP2 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_core [C_DEPTH];
  logic [W-1:0]  r_tmp;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_b;
  logic          r_swap_done;
  logic          r_wr_drop;
  logic          w_idle;
  logic          w_wr_acc;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_acc = wr_en & w_idle & ~swap_req;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (swap_req) w_state_nxt = ST_SWAP1;
      ST_SWAP1: w_state_nxt = ST_SWAP2;
      ST_SWAP2: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Swap goes through the single write port: a->tmp/b->a first, then tmp->b.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) r_core[i] <= '0;
      r_tmp       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_swap_done <= 1'b0;
      r_wr_drop   <= 1'b0;
    end else begin
      r_swap_done <= (r_state == ST_SWAP2);
      r_wr_drop   <= wr_en & ~w_wr_acc;
      case (r_state)
        ST_IDLE: begin
          if (swap_req) begin
            r_a <= swap_a;
            r_b <= swap_b;
          end else if (wr_en) begin
            r_core[wr_addr] <= dat_in;
          end
        end
        ST_SWAP1: begin
          r_tmp       <= r_core[r_a];
          r_core[r_a] <= r_core[r_b];
        end
        ST_SWAP2: r_core[r_b] <= r_tmp;
        default: ;
      endcase
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign datA_out = (w_wr_acc && wr_addr == rd_addrA) ? dat_in : r_core[rd_addrA];
      assign datB_out = (w_wr_acc && wr_addr == rd_addrB) ? dat_in : r_core[rd_addrB];
    end else begin : g_no_bypass
      assign datA_out = r_core[rd_addrA];
      assign datB_out = r_core[rd_addrB];
    end
  endgenerate

  assign busy      = ~w_idle;
  assign swap_done = r_swap_done;
  assign wr_drop   = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_swap.sv
`default_nettype none
// Self-checking bench for reg_file_swap: directed steps plus random traffic
// compared against a cycle-level behavioural model.
module tb_reg_file_swap;
  localparam int W      = 8;
  localparam int AW     = 2;
  localparam int BYPASS = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, wr_en, swap_req;
  logic [AW-1:0] wr_addr, rd_addrA, rd_addrB, swap_a, swap_b;
  logic [W-1:0]  dat_in, datA_out, datB_out;
  logic          busy, swap_done, wr_drop;

  int n_checks = 0;
  int n_errors = 0;

  // Model: memory image plus a countdown of swap cycles still to run.
  logic [W-1:0]  m_mem [DEPTH];
  int            m_cnt;
  logic [AW-1:0] m_a, m_b;
  logic [W-1:0]  m_va, m_vb;
  logic          m_done, m_drop;

  reg_file_swap #(.W(W), .AW(AW), .BYPASS(BYPASS)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(datA_out), .datB_out(datB_out),
    .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
    .busy(busy), .swap_done(swap_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] ad);
    if (BYPASS != 0 && wr_en && m_cnt == 0 && !swap_req && wr_addr == ad) return dat_in;
    return m_mem[ad];
  endfunction

  task automatic model_edge();
    logic nd, ndr;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_cnt = 0; m_done = 0; m_drop = 0;
    end else begin
      nd  = (m_cnt == 1);
      ndr = wr_en && (m_cnt != 0 || swap_req);
      if (m_cnt == 2) begin
        m_mem[m_a] = m_vb; m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_mem[m_b] = m_va; m_cnt = 0;
      end else if (swap_req) begin
        m_a = swap_a; m_b = swap_b; m_va = m_mem[swap_a]; m_vb = m_mem[swap_b]; m_cnt = 2;
      end else if (wr_en) begin
        m_mem[wr_addr] = dat_in;
      end
      m_done = nd; m_drop = ndr;
    end
  endtask

  // Compare all outputs mid-cycle, then advance one edge.
  task automatic tick(input bit do_check);
    #3;
    if (do_check) begin
      check("datA", datA_out, m_read(rd_addrA));
      check("datB", datB_out, m_read(rd_addrB));
      check("busy", {7'd0, busy}, {7'd0, m_cnt != 0});
      check("swap_done", {7'd0, swap_done}, {7'd0, m_done});
      check("wr_drop", {7'd0, wr_drop}, {7'd0, m_drop});
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    reset = 0; wr_en = 0; swap_req = 0;
  endtask

  initial begin
    idle_in();
    wr_addr = 0; dat_in = 0; rd_addrA = 0; rd_addrB = 0; swap_a = 0; swap_b = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    m_cnt = 0; m_done = 0; m_drop = 0;
    @(posedge clk); #1;
    reset = 1; tick(0); tick(0);
    idle_in();

    // 1: all zero after reset
    for (int i = 0; i < DEPTH; i++) begin
      rd_addrA = i[AW-1:0]; rd_addrB = i[AW-1:0];
      #3; check("rst_zero", datA_out, 8'h00); #0 ;
      tick(1);
    end

    // 2: writes and bypass
    wr_en = 1; wr_addr = 1; dat_in = 8'hA5; tick(1);
    wr_addr = 2; dat_in = 8'h3C; tick(1);
    wr_en = 0; rd_addrA = 1; rd_addrB = 2; #3;
    check("rd_r1", datA_out, 8'hA5); check("rd_r2", datB_out, 8'h3C); tick(1);
    wr_en = 1; wr_addr = 3; dat_in = 8'h7E; rd_addrA = 3; #3;
    check("bypass", datA_out, (BYPASS != 0) ? 8'h7E : 8'h00); tick(1);
    wr_en = 0;

    // 3: swap r1/r2
    swap_req = 1; swap_a = 1; swap_b = 2; tick(1);
    swap_req = 0; tick(1); tick(1);
    rd_addrA = 1; rd_addrB = 2; #3;
    check("swap_done_pulse", {7'd0, swap_done}, 8'h01);
    check("swap_r1", datA_out, 8'h3C); check("swap_r2", datB_out, 8'hA5); tick(1);

    // 4: self-swap, then write raised with swap
    swap_req = 1; swap_a = 3; swap_b = 3; tick(1);
    swap_req = 0; tick(1); tick(1);
    rd_addrA = 3; #3; check("self_swap", datA_out, 8'h7E); tick(1);
    swap_req = 1; swap_a = 1; swap_b = 2; wr_en = 1; wr_addr = 0; dat_in = 8'hFF; tick(1);
    swap_req = 0; wr_en = 0; #3; check("drop_pulse", {7'd0, wr_drop}, 8'h01); tick(1);
    tick(1); tick(1);
    rd_addrA = 0; #3; check("r0_kept", datA_out, 8'h00); tick(1);

    // 5: write during busy
    swap_req = 1; swap_a = 0; swap_b = 3; tick(1);
    swap_req = 0; wr_en = 1; wr_addr = 0; dat_in = 8'h11; tick(1);
    wr_en = 0; tick(1); tick(1);
    rd_addrA = 0; rd_addrB = 3; #3;
    check("r0_after_swap", datA_out, 8'h7E); check("r3_after_swap", datB_out, 8'h00); tick(1);

    // 6: reset during SWAP1
    swap_req = 1; swap_a = 1; swap_b = 2; tick(1);
    swap_req = 0; reset = 1; tick(1);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addrA = i[AW-1:0]; #3; check("rst_abort", datA_out, 8'h00); tick(1);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      wr_en    = $urandom_range(0, 1);
      swap_req = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom); dat_in = W'($urandom);
      rd_addrA = AW'($urandom); rd_addrB = AW'($urandom);
      swap_a   = AW'($urandom); swap_b = AW'($urandom);
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
